// File: rtl/synthia_pwm_decoder_pkg.sv
// Shared constants, crossing-state type and helpers for the Synthia PWM decoder.
package synthia_pkg;
  localparam int FRAME_LEN_DEF = 256;
  localparam int MID           = 128;
  localparam int HYST_DEF      = 16;
  localparam int PERIOD_W      = 16;
  localparam int SYNC_STAGES   = 2;

  typedef enum logic {
    CROSS_LOW  = 1'b0,
    CROSS_HIGH = 1'b1
  } cross_state_t;

  // A full frame of high time scales to 256, which must read as 255.
  function automatic logic [7:0] sat_u8(input logic [8:0] v);
    return (v > 9'd255) ? 8'd255 : v[7:0];
  endfunction
endpackage

// File: rtl/synthia_pwm_decoder_if.sv
// Link between the decoder top and its duty-frame measurement block.
interface synthia_pwm_decoder_if;
  logic       run;
  logic       pwm;
  logic       frame_end;
  logic [7:0] sample;

  modport master (output run, output pwm, input frame_end, input sample);
  modport slave  (input run, input pwm, output frame_end, output sample);
endinterface

// File: rtl/synthia_duty_frame.sv
// Counts high cycles of the synchronized PWM over fixed frames and scales the count to 8 bits.
module synthia_duty_frame
  import synthia_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  synthia_pwm_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int SHIFT = $clog2(256 / FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] frame_cnt_reg;
  logic [CNT_W:0]   high_cnt_reg;
  logic [CNT_W:0]   high_total;
  logic [8:0]       scaled;

  // The last frame cycle's own pwm level is part of the sample.
  always_comb begin
    high_total    = high_cnt_reg + {{CNT_W{1'b0}}, bus.pwm};
    scaled        = 9'(high_total) << SHIFT;
    bus.sample    = sat_u8(scaled);
    bus.frame_end = bus.run && (frame_cnt_reg == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.run) begin
      frame_cnt_reg <= '0;
      high_cnt_reg  <= '0;
    end else if (frame_cnt_reg == LAST) begin
      frame_cnt_reg <= '0;
      high_cnt_reg  <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      high_cnt_reg  <= high_total;
    end
  end
endmodule

// File: rtl/synthia_pwm_decoder.sv
// Decodes the Synthia PWM audio stream into duty samples with a ready/valid handshake,
// and measures tone period from hysteretic midpoint crossings of those samples.
module synthia_pwm_decoder
  import synthia_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int HYST      = HYST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                pwm_i,
  input  logic                sample_ready_i,
  output logic [7:0]          sample_o,
  output logic                sample_valid_o,
  output logic                overrun_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                silent_o
);
  localparam logic [7:0] RISE_TH = 8'(MID + HYST);
  localparam logic [7:0] FALL_TH = 8'(MID - HYST);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [7:0]             sample_reg;
  logic                   valid_reg;
  logic                   overrun_reg;
  logic [PERIOD_W-1:0]    period_cnt_reg;
  logic [PERIOD_W-1:0]    period_reg;
  logic                   period_valid_reg;
  logic                   silent_reg;
  logic                   armed_reg;
  cross_state_t           cross_state_reg;
  cross_state_t           cross_state_next;
  logic                   rise;

  synthia_pwm_decoder_if frame_bus ();

  assign frame_bus.run = en;
  assign frame_bus.pwm = sync_reg[SYNC_STAGES-1];

  synthia_duty_frame #(.FRAME_LEN(FRAME_LEN)) u_frame (
    .clk   (clk),
    .reset (reset),
    .bus   (frame_bus)
  );

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_i};
  end

  // Sample register: a new frame always wins over acceptance on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (!en) begin
      valid_reg <= 1'b0;
    end else if (frame_bus.frame_end) begin
      sample_reg <= frame_bus.sample;
      valid_reg  <= 1'b1;
      if (valid_reg && !sample_ready_i) overrun_reg <= 1'b1;
    end else if (valid_reg && sample_ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !en) cross_state_reg <= CROSS_LOW;
    else              cross_state_reg <= cross_state_next;
  end

  always_comb begin
    cross_state_next = cross_state_reg;
    rise             = 1'b0;
    if (frame_bus.frame_end) begin
      case (cross_state_reg)
        CROSS_LOW: begin
          if (frame_bus.sample >= RISE_TH) begin
            cross_state_next = CROSS_HIGH;
            rise             = 1'b1;
          end
        end
        CROSS_HIGH: begin
          if (frame_bus.sample <= FALL_TH) cross_state_next = CROSS_LOW;
        end
        default: cross_state_next = CROSS_LOW;
      endcase
    end
  end

  // Period meter: the first rising crossing after arming only starts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_reg   <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      silent_reg       <= 1'b1;
      armed_reg        <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      if (!en) begin
        period_cnt_reg <= '0;
        armed_reg      <= 1'b0;
      end else if (rise) begin
        if (armed_reg) begin
          period_reg       <= period_cnt_reg;
          period_valid_reg <= 1'b1;
          silent_reg       <= 1'b0;
        end
        period_cnt_reg <= PERIOD_W'(1);
        armed_reg      <= 1'b1;
      end else if (period_cnt_reg == '1) begin
        period_reg <= '0;
        silent_reg <= 1'b1;
        armed_reg  <= 1'b0;
      end else begin
        period_cnt_reg <= period_cnt_reg + PERIOD_W'(1);
      end
    end
  end

  assign sample_o       = sample_reg;
  assign sample_valid_o = valid_reg;
  assign overrun_o      = overrun_reg;
  assign period_o       = period_reg;
  assign period_valid_o = period_valid_reg;
  assign silent_o       = silent_reg;
endmodule

// File: tb/tb_synthia_pwm_decoder.sv
// Scoreboard bench for synthia_pwm_decoder: directed PWM segments push expected samples/periods,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_synthia_pwm_decoder;
  import synthia_pkg::*;

  localparam int FL = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_ready_i;
  logic [7:0]  sample_o;
  logic        sample_valid_o;
  logic        overrun_o;
  logic [15:0] period_o;
  logic        period_valid_o;
  logic        silent_o;

  synthia_pwm_decoder_if bus ();

  always #5 clk = ~clk;

  synthia_pwm_decoder #(.FRAME_LEN(FL), .HYST(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (bus.run),
    .pwm_i          (bus.pwm),
    .sample_ready_i (sample_ready_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .overrun_o      (overrun_o),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .silent_o       (silent_o)
  );

  assign bus.sample    = sample_o;
  assign bus.frame_end = sample_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_samples[$];
  int exp_periods[$];
  int last_pv_cyc     = -1;
  int silent_rise_cyc = -1;
  int first_valid     = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int d_high(input int f);
    case (f)
      0: return 64;
      1: return 100;
      2: return 200;
      3: return 32;
      4: return 160;
      default: return 0;
    endcase
  endfunction

  // kind: 0 always high, 1 half duty, 2 tone 10/10 frames, 3 overrun table, 4 reset mid-frame
  function automatic logic pat(input int kind, input int j);
    int f;
    f = j / FL;
    case (kind)
      1: return (j % FL) < 128;
      2: return (f < 50) && ((f / 10) % 2 == 0);
      3: return (j % FL) < d_high(f);
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: acceptances and period pulses, decoupled from stimulus.
  initial begin
    int  e;
    logic pv_prev;
    logic silent_prev;
    pv_prev     = 1'b0;
    silent_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (bus.frame_end && sample_ready_i) begin
          if (exp_samples.size() == 0) begin
            check("sample_unexpected", int'(bus.sample), -1);
          end else begin
            e = exp_samples.pop_front();
            $display("cyc %0d sample accepted %0d (expected %0d)", cyc, bus.sample, e);
            check("sample", int'(bus.sample), e);
          end
        end
        if (period_valid_o) begin
          check("period_valid_width", int'(pv_prev), 0);
          last_pv_cyc = cyc;
          if (exp_periods.size() == 0) begin
            check("period_unexpected", int'(period_o), -1);
          end else begin
            e = exp_periods.pop_front();
            $display("cyc %0d period %0d (expected %0d)", cyc, period_o, e);
            check("period", int'(period_o), e);
          end
        end
        if (silent_o && !silent_prev) silent_rise_cyc = cyc;
      end
      pv_prev     = period_valid_o;
      silent_prev = silent_o;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_sample"}, int'(sample_o), 0);
    check({tag, "_valid"}, int'(sample_valid_o), 0);
    check({tag, "_overrun"}, int'(overrun_o), 0);
    check({tag, "_period"}, int'(period_o), 0);
    check({tag, "_period_valid"}, int'(period_valid_o), 0);
    check({tag, "_silent"}, int'(silent_o), 1);
  endtask

  task automatic run_seg(input int kind, input int len);
    int ev;
    if (kind <= 2) begin
      for (int f = 0; FL * f + 258 <= len - 1; f++) begin
        if (kind == 0) ev = 255;
        else if (kind == 1) ev = 128;
        else ev = ((f < 50) && ((f / 10) % 2 == 0)) ? 255 : 0;
        exp_samples.push_back(ev);
      end
    end
    for (int j = 0; j < len; j++) begin
      bus.pwm = pat(kind, j);
      bus.run = (j >= 2);
      sample_ready_i = (kind == 3) ? ((j == 513) || (j >= 1290)) : 1'b1;
      reset = (kind == 4) && (j == 102);
      if (kind == 1 && j >= 258 && (j % FL) == 2)
        check("fsm_low", int'(dut.cross_state_reg), int'(CROSS_LOW));
      if (kind == 3) begin
        case (j)
          258: begin
            check("ovr_f0_sample", int'(sample_o), 64);
            check("ovr_f0_valid", int'(sample_valid_o), 1);
            check("ovr_f0_overrun", int'(overrun_o), 0);
          end
          514: begin
            check("coincide_sample", int'(sample_o), 100);
            check("coincide_valid", int'(sample_valid_o), 1);
            check("coincide_overrun", int'(overrun_o), 0);
          end
          770: begin
            check("ovr_f2_sample", int'(sample_o), 200);
            check("ovr_f2_overrun", int'(overrun_o), 1);
          end
          1282: begin
            check("ovr_third_sample", int'(sample_o), 160);
            check("ovr_third_valid", int'(sample_valid_o), 1);
            check("ovr_third_overrun", int'(overrun_o), 1);
          end
          1295: begin
            check("ovr_after_ready_valid", int'(sample_valid_o), 0);
            check("ovr_sticky", int'(overrun_o), 1);
          end
          default: ;
        endcase
      end
      if (kind == 4) begin
        if (j == 103) check_reset_state("midframe_reset");
        if (j >= 103 && first_valid < 0 && sample_valid_o) first_valid = j;
      end
      step();
    end
    bus.run = 1'b0;
    reset   = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.pwm        = 1'b0;
    sample_ready_i = 1'b1;
    step();
    step();
    step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // Constant high: full-scale samples, no period, stays silent.
    run_seg(0, 3 * FL + 10);
    check("high_period", int'(period_o), 0);
    check("high_silent", int'(silent_o), 1);

    // Half duty sits inside the hysteresis band.
    run_seg(1, 3 * FL + 10);

    // Tone at 20 frames per period, then silence after the last rise.
    exp_periods.push_back(5120);
    exp_periods.push_back(5120);
    silent_rise_cyc = -1;
    run_seg(2, 76100);
    check("silent_delay", silent_rise_cyc - last_pv_cyc, 65535);
    check("silent_period", int'(period_o), 0);
    check("silent_flag", int'(silent_o), 1);

    // Back-pressure: coincident load/accept, then three overwrites.
    check("pre_overrun", int'(overrun_o), 0);
    exp_samples.push_back(64);
    exp_samples.push_back(160);
    exp_periods.push_back(512);
    run_seg(3, 1300);

    // Reset at frame count 100; synchronizer clear costs two high cycles.
    exp_samples.push_back(254);
    first_valid = -1;
    run_seg(4, 370);
    check("first_valid_delay", first_valid - 103 + 1, FL + 1);

    check("sample_queue_empty", exp_samples.size(), 0);
    check("period_queue_empty", exp_periods.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
